systolic_feeder: RTL and testbench

Input-side counterpart of the systolic matrix processor. It accepts one matrix tile as a stream, with row i of A and column i of B in each beat, and stores both in local register banks. It then drives the array's skewed diagonal inputs (a_full, b_full, valid) together with an accumulator-clear pulse. It sits between the AXI-stream ingress buffer and the processor array.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_skew_lane.sv | 37 +++
 rtl/systolic_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding and tile-size helpers shared by the
// systolic feeder and its skew lanes.
package systolic_pkg;

  localparam int SIZE_DEF   = 4;
  localparam int I_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FEED,
    ST_DRAIN
  } state_t;

  // 0 or anything above the array size means "full tile"
  function automatic int clamp_n(
    input logic [2:0] req,
    input int         size
  );
    if (req == 3'd0 || int'(req) > size) return size;
    return int'(req);
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// systolic_skew_lane: picks element t-K of one bank entry for lane K,
// or zero outside the skew window / active tile.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int I_BITS = I_BITS_DEF,
  parameter int K      = 0,
  parameter int CW     = 5,
  parameter int NW     = 3
) (
  input  logic                   i_en,
  input  logic [CW-1:0]          i_t,
  input  logic [NW-1:0]          i_n,
  input  logic [SIZE*I_BITS-1:0] i_elems,
  output logic [I_BITS-1:0]      o_elem
);

  logic [CW-1:0] w_idx;
  logic          w_live;

  assign w_idx  = i_t - CW'(K);
  assign w_live = i_en
               && (CW'(K) < CW'(i_n))
               && (i_t >= CW'(K))
               && (w_idx < CW'(i_n));

  always_comb begin
    o_elem = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (w_live && w_idx == CW'(j)) begin
        o_elem = i_elems[j*I_BITS +: I_BITS];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads an A/B tile from a stream, then feeds skewed
// diagonals to the array. FEEDER_PERF_CNT_EN adds o_perf_cycles.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int I_BITS       = I_BITS_DEF,
  parameter int DRAIN_CYCLES = 2 * SIZE
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [SIZE*I_BITS-1:0] i_s_a_row,
  input  logic [SIZE*I_BITS-1:0] i_s_b_col,
  input  logic                   i_s_last,
  input  logic [2:0]             rf_matrix_size,
  output logic                   o_valid,
  output logic [SIZE*I_BITS-1:0] o_a_full,
  output logic [SIZE*I_BITS-1:0] o_b_full,
  output logic                   o_acc_reset,
  output logic                   o_busy,
  output logic                   o_done,
`ifdef FEEDER_PERF_CNT_EN
  output logic [31:0]            o_perf_cycles,
`endif
  output logic                   o_tile_err
);

  localparam int NW = $clog2(SIZE + 1);
  localparam int CW = $clog2(2 * SIZE + DRAIN_CYCLES + 1);
  localparam int VW = SIZE * I_BITS;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_t_last;
  logic [NW-1:0] r_n, w_n_nxt, w_n_beat;
  logic [VW-1:0] r_a_bank [SIZE];
  logic [VW-1:0] r_b_bank [SIZE];
  logic [VW-1:0] w_a_nxt  [SIZE];
  logic [VW-1:0] w_b_nxt  [SIZE];
  logic [VW-1:0] w_a_lane, w_b_lane;
  logic [VW-1:0] r_a_full, r_b_full;
  logic          w_hs, w_last_beat, w_mismatch;
  logic          w_valid_nxt, w_acc_nxt, w_done_nxt;
  logic          r_s_ready, r_valid, r_acc, r_busy, r_done, r_err;

  assign o_s_ready   = r_s_ready;
  assign o_valid     = r_valid;
  assign o_a_full    = r_a_full;
  assign o_b_full    = r_b_full;
  assign o_acc_reset = r_acc;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_tile_err  = r_err;

  assign w_hs        = i_s_valid && r_s_ready;
  assign w_n_beat    = (r_cnt == '0)
                     ? NW'(clamp_n(rf_matrix_size, SIZE))
                     : r_n;
  assign w_last_beat = (r_cnt == CW'(w_n_beat) - CW'(1));
  assign w_mismatch  = (i_s_last != w_last_beat);
  assign w_t_last    = CW'(r_n) + CW'(r_n) - CW'(2);

  // banks as they will be after this edge, so t=0 sees the last beat
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_a_nxt[i] = r_a_bank[i];
      w_b_nxt[i] = r_b_bank[i];
      if (w_hs && r_cnt == CW'(i)) begin
        w_a_nxt[i] = i_s_a_row;
        w_b_nxt[i] = i_s_b_col;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    unique case (r_state)
      ST_LOAD: begin
        if (w_hs) begin
          w_n_nxt = w_n_beat;
          if (w_last_beat) begin
            w_state_nxt = ST_FEED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (r_cnt == w_t_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_valid_nxt = (w_state_nxt == ST_FEED);
  assign w_acc_nxt   = w_valid_nxt && (w_cnt_nxt == '0);
  assign w_done_nxt  = (w_state_nxt == ST_DRAIN)
                    && (w_cnt_nxt == CW'(DRAIN_CYCLES - 1));

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    systolic_skew_lane #(
      .SIZE(SIZE), .I_BITS(I_BITS), .K(k), .CW(CW), .NW(NW)
    ) u_a (
      .i_en   (w_valid_nxt),
      .i_t    (w_cnt_nxt),
      .i_n    (w_n_nxt),
      .i_elems(w_a_nxt[k]),
      .o_elem (w_a_lane[k*I_BITS +: I_BITS])
    );
    systolic_skew_lane #(
      .SIZE(SIZE), .I_BITS(I_BITS), .K(k), .CW(CW), .NW(NW)
    ) u_b (
      .i_en   (w_valid_nxt),
      .i_t    (w_cnt_nxt),
      .i_n    (w_n_nxt),
      .i_elems(w_b_nxt[k]),
      .o_elem (w_b_lane[k*I_BITS +: I_BITS])
    );
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      r_n       <= '0;
      r_s_ready <= 1'b1;
      r_valid   <= 1'b0;
      r_acc     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_a_full  <= '0;
      r_b_full  <= '0;
      for (int i = 0; i < SIZE; i++) begin
        r_a_bank[i] <= '0;
        r_b_bank[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_n       <= w_n_nxt;
      r_s_ready <= (w_state_nxt == ST_LOAD);
      r_valid   <= w_valid_nxt;
      r_acc     <= w_acc_nxt;
      r_busy    <= (w_state_nxt != ST_LOAD);
      r_done    <= w_done_nxt;
      r_a_full  <= w_a_lane;
      r_b_full  <= w_b_lane;
      for (int i = 0; i < SIZE; i++) begin
        r_a_bank[i] <= w_a_nxt[i];
        r_b_bank[i] <= w_b_nxt[i];
      end
      if (w_hs) begin
        r_err <= w_mismatch | (r_err & (r_cnt != '0));
      end
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic        r_perf_run;
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_out;

  assign o_perf_cycles = r_perf_out;

  // starts at 2: the first beat plus the one-cycle feed latency
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_run <= 1'b0;
      r_perf_cnt <= '0;
      r_perf_out <= '0;
    end else begin
      if (w_hs && r_cnt == '0) begin
        r_perf_run <= 1'b1;
        r_perf_cnt <= 32'd2;
      end else if (r_perf_run && r_perf_cnt != '1) begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
      if (r_done) begin
        r_perf_run <= 1'b0;
        r_perf_out <= (r_perf_cnt == '1) ? r_perf_cnt
                                         : r_perf_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: expected skewed vectors are queued when a
// tile is driven and compared as the feeder emits them.
`timescale 1ns/1ps
module tb_systolic_feeder;

  localparam int SIZE  = 4;
  localparam int IB    = 8;
  localparam int VW    = SIZE * IB;
  localparam int DRAIN = 2 * SIZE;

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          acc;
  } vec_t;

  logic          i_clock, i_reset, i_s_valid, i_s_last;
  logic          o_s_ready, o_valid, o_acc_reset;
  logic          o_busy, o_done, o_tile_err;
  logic [VW-1:0] i_s_a_row, i_s_b_col, o_a_full, o_b_full;
  logic [2:0]    rf_matrix_size;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]   o_perf_cycles;
`endif

  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   since    = 0;
  bit   seen     = 0;
  vec_t exp_q[$];
  int   A[SIZE][SIZE];
  int   B[SIZE][SIZE];

  systolic_feeder dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .i_s_a_row     (i_s_a_row),
    .i_s_b_col     (i_s_b_col),
    .i_s_last      (i_s_last),
    .rf_matrix_size(rf_matrix_size),
    .o_valid       (o_valid),
    .o_a_full      (o_a_full),
    .o_b_full      (o_b_full),
    .o_acc_reset   (o_acc_reset),
    .o_busy        (o_busy),
    .o_done        (o_done),
`ifdef FEEDER_PERF_CNT_EN
    .o_perf_cycles (o_perf_cycles),
`endif
    .o_tile_err    (o_tile_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clock) begin
    vec_t e;
    if (!i_reset) begin
      exp_q.delete();
      seen  = 0;
      since = 0;
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_valid", o_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("a_full", o_a_full, e.a);
          chk("b_full", o_b_full, e.b);
          chk("acc_reset", o_acc_reset, e.acc);
        end
        chk("ready_feed", o_s_ready, 1'b0);
        chk("busy_feed", o_busy, 1'b1);
        seen  = 1;
        since = 0;
      end else begin
        chk("idle_out", {o_a_full, o_b_full, o_acc_reset}, '0);
        if (seen) begin
          since++;
          chk("busy_drain", o_busy, 1'b1);
          chk("ready_drain", o_s_ready, 1'b0);
        end
      end
      if (o_done) begin
        chk("done_lat", since, DRAIN);
        done_cnt++;
        seen = 0;
      end
    end
  end

  task automatic push_expect(input int n);
    vec_t e;
    for (int t = 0; t <= 2 * n - 2; t++) begin
      e = '0;
      for (int k = 0; k < n; k++) begin
        int j;
        j = t - k;
        if (j >= 0 && j < n) begin
          e.a[k*IB +: IB] = 8'(A[k][j]);
          e.b[k*IB +: IB] = 8'(B[j][k]);
        end
      end
      e.acc = (t == 0);
      exp_q.push_back(e);
    end
  endtask

  // returns at the negedge of the first FEED cycle
  task automatic send_tile(input logic [2:0] req, input int gapmax,
                           input bit bad_last, input bit jiggle);
    int n;
    bit hs;
    n = (req == 3'd0 || int'(req) > SIZE) ? SIZE : int'(req);
    rf_matrix_size = req;
    push_expect(n);
    for (int r = 0; r < n; r++) begin
      if (gapmax > 0) begin
        repeat ($urandom_range(0, gapmax)) begin
          @(posedge i_clock);
          #1;
        end
      end
      for (int c = 0; c < SIZE; c++) begin
        i_s_a_row[c*IB +: IB] = (c < n) ? 8'(A[r][c]) : 8'hA5;
        i_s_b_col[c*IB +: IB] = (c < n) ? 8'(B[c][r]) : 8'h5A;
      end
      i_s_last  = (r == n - 1) || (bad_last && r == 0);
      i_s_valid = 1'b1;
      hs = 0;
      for (int w = 0; w < 50 && !hs; w++) begin
        @(negedge i_clock);
        hs = o_s_ready;
        @(posedge i_clock);
        #1;
      end
      chk("beat_hs", hs, 1'b1);
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      if (jiggle && r == 0) rf_matrix_size = 3'd1;
    end
    @(negedge i_clock);
    chk("first_valid", o_valid, 1'b1);
  endtask

  task automatic wait_done(input int prev);
    for (int w = 0; w < 200 && done_cnt == prev; w++) begin
      @(posedge i_clock);
    end
    #1;
    chk("done_seen", done_cnt, prev + 1);
    chk("q_empty", exp_q.size(), 0);
    chk("ready_load", o_s_ready, 1'b1);
    chk("busy_load", o_busy, 1'b0);
  endtask

  task automatic fill(input int base_a, input int mul_a,
                      input int base_b, input int mul_b);
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        A[r][c] = base_a + mul_a * r + c;
        B[r][c] = base_b + mul_b * r + c;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int prev;
    i_reset = 1'b0;
    i_s_valid = 1'b0;
    i_s_last = 1'b0;
    i_s_a_row = '0;
    i_s_b_col = '0;
    rf_matrix_size = 3'd2;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_ready", o_s_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_tile_err, 1'b0);
    chk("rst_data", {o_a_full, o_b_full, o_acc_reset}, '0);
    @(posedge i_clock);
    #1 i_reset = 1'b1;

    // N=2 reference tile
    fill(0, 0, 0, 0);
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    prev = done_cnt;
    send_tile(3'd2, 0, 0, 0);
    chk("err_good", o_tile_err, 1'b0);
    wait_done(prev);

    // N=4 full tile with gaps, size register changed mid-tile
    fill(1, 4, 17, 4);
    prev = done_cnt;
    send_tile(3'd4, 3, 0, 1);
    wait_done(prev);

    // clamped sizes
    fill(100, 16, 200, -5);
    prev = done_cnt;
    send_tile(3'd0, 0, 0, 0);
    wait_done(prev);
    fill(60, 7, 150, 9);
    prev = done_cnt;
    send_tile(3'd7, 1, 0, 0);
    wait_done(prev);

    // bad i_s_last on beat 0
    fill(20, 3, 90, 2);
    prev = done_cnt;
    send_tile(3'd2, 0, 1, 0);
    chk("err_set", o_tile_err, 1'b1);
    wait_done(prev);
    chk("err_sticky", o_tile_err, 1'b1);
    fill(33, 5, 77, 6);
    prev = done_cnt;
    send_tile(3'd2, 0, 0, 0);
    chk("err_clear", o_tile_err, 1'b0);
    wait_done(prev);

    // reset at FEED t=1
    fill(11, 2, 44, 3);
    prev = done_cnt;
    send_tile(3'd2, 0, 0, 0);
    @(negedge i_clock);
    #1 i_reset = 1'b0;
    #1;
    chk("abort_valid", o_valid, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_ready", o_s_ready, 1'b1);
    @(negedge i_clock);
    #1 i_reset = 1'b1;
    repeat (20) @(posedge i_clock);
    #1;
    chk("abort_no_done", done_cnt, prev);
    fill(5, 9, 70, 4);
    prev = done_cnt;
    send_tile(3'd2, 0, 0, 0);
    wait_done(prev);

    // N=1
    fill(0, 0, 0, 0);
    A[0][0] = 9;
    B[0][0] = 3;
    prev = done_cnt;
    send_tile(3'd1, 0, 0, 0);
    chk("n1_acc", o_acc_reset, 1'b1);
    wait_done(prev);
`ifdef FEEDER_PERF_CNT_EN
    chk("perf_cycles", o_perf_cycles, 32'd11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
